// File: rtl/sdram_pattern_tester_if.sv
// sdram_pattern_tester_if: request/ack bus between the pattern tester and an SDRAM controller.
//
// Signals:
//   sdram_req        tester -> ctrl   request strobe, held until ack
//   sdram_ack        ctrl -> tester   request accepted
//   sdram_addr       tester -> ctrl   word address
//   sdram_rh_wl      tester -> ctrl   1 = read, 0 = write
//   sdram_data_w     tester -> ctrl   write data
//   sdram_data_r     ctrl -> tester   read data
//   sdram_data_r_en  ctrl -> tester   read data valid
// Modports: master (tester side), slave (controller side).
interface sdram_pattern_tester_if #(
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  sdram_req;
  logic                  sdram_ack;
  logic [ADDR_WIDTH-1:0] sdram_addr;
  logic                  sdram_rh_wl;
  logic [DATA_WIDTH-1:0] sdram_data_w;
  logic [DATA_WIDTH-1:0] sdram_data_r;
  logic                  sdram_data_r_en;

  modport master (
    output sdram_req, sdram_addr, sdram_rh_wl, sdram_data_w,
    input  sdram_ack, sdram_data_r, sdram_data_r_en
  );

  modport slave (
    input  sdram_req, sdram_addr, sdram_rh_wl, sdram_data_w,
    output sdram_ack, sdram_data_r, sdram_data_r_en
  );
endinterface

// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester: writes WORD_COUNT words of a known pattern through an SDRAM
// controller, reads them back and counts mismatches.
//
// Ports:
//   clk             single rising-edge clock
//   reset           synchronous, active-high
//   start           one-cycle pulse, starts a run (ignored while busy)
//   sdram           controller bus (master modport of sdram_pattern_tester_if)
//   busy            run in progress
//   done            last run finished (pass, fail or timeout)
//   pass            last run finished with no mismatch and no timeout
//   timeout         last run aborted on a missing controller response
//   err_cnt         mismatched words, saturating
//   first_err_addr  address of the first mismatch
//   led             status: 55 pass, AA errors, F0 timeout, 01 busy, 00 idle
//
// Build option: define SDRAM_TESTER_LFSR_EN to use a 16-bit Fibonacci LFSR
// (x^16+x^14+x^13+x^11+1, seed ACE1) as the data pattern instead of i ^ 5A5A.
module sdram_pattern_tester #(
  parameter int unsigned ADDR_WIDTH  = 24,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned WORD_COUNT  = 256,
  parameter int unsigned START_ADDR  = 0,
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  sdram_pattern_tester_if.master sdram,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [15:0]            err_cnt,
  output logic [ADDR_WIDTH-1:0]  first_err_addr,
  output logic [7:0]             led
);

  localparam int unsigned WaitW = $clog2(ACK_TIMEOUT + 2);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StDone, StTmo} state_e;

  state_e                state_q;
  logic [15:0]           idx_q;
  logic [WaitW-1:0]      wait_q;
  logic                  rd_pend_q;  // read acked, data beat still due

  logic [15:0]           pat16;
  logic [DATA_WIDTH-1:0] pattern;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  start_go;
  logic                  rd_beat;
  logic                  mismatch;
  logic                  last_word;
  logic                  timed_out;

  assign word_addr = ADDR_WIDTH'(START_ADDR) + ADDR_WIDTH'(idx_q);
  assign start_go  = start && (state_q == StIdle || state_q == StDone || state_q == StTmo);
  assign rd_beat   = (state_q == StRead) && rd_pend_q && sdram.sdram_data_r_en;
  assign mismatch  = rd_beat && (sdram.sdram_data_r != pattern);
  assign last_word = idx_q == 16'(WORD_COUNT - 1);
  assign timed_out = wait_q == WaitW'(ACK_TIMEOUT);
  assign pattern   = DATA_WIDTH'(pat16);

`ifdef SDRAM_TESTER_LFSR_EN
  logic [15:0] lfsr_q;
  logic        wr_ack;

  assign wr_ack = (state_q == StWrite) && sdram.sdram_req && sdram.sdram_ack;
  assign pat16  = lfsr_q;

  // Reseeded as each phase begins so the read phase replays the write sequence.
  always_ff @(posedge clk) begin
    if (reset || start_go || (wr_ack && last_word)) begin
      lfsr_q <= 16'hACE1;
    end else if (wr_ack || rd_beat) begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end
`else
  assign pat16 = idx_q ^ 16'h5A5A;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= StIdle;
      idx_q              <= '0;
      wait_q             <= '0;
      rd_pend_q          <= 1'b0;
      sdram.sdram_req    <= 1'b0;
      sdram.sdram_rh_wl  <= 1'b1;
      sdram.sdram_addr   <= '0;
      sdram.sdram_data_w <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      pass               <= 1'b0;
      timeout            <= 1'b0;
      err_cnt            <= '0;
      first_err_addr     <= '0;
      led                <= 8'h00;
    end else begin
      case (state_q)
        StIdle, StDone, StTmo: begin
          if (start_go) begin
            state_q        <= StWrite;
            idx_q          <= '0;
            rd_pend_q      <= 1'b0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            led            <= 8'h01;
          end
        end

        StWrite: begin
          if (!sdram.sdram_req) begin
            sdram.sdram_req    <= 1'b1;
            sdram.sdram_addr   <= word_addr;
            sdram.sdram_rh_wl  <= 1'b0;
            sdram.sdram_data_w <= pattern;
            wait_q             <= '0;
          end else if (sdram.sdram_ack) begin
            sdram.sdram_req <= 1'b0;
            if (last_word) begin
              state_q <= StRead;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 16'd1;
            end
          end else if (timed_out) begin
            state_q         <= StTmo;
            sdram.sdram_req <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b1;
            timeout         <= 1'b1;
            led             <= 8'hF0;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end

        StRead: begin
          if (rd_pend_q) begin
            if (sdram.sdram_data_r_en) begin
              rd_pend_q <= 1'b0;
              if (mismatch) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                if (err_cnt == 16'd0) first_err_addr <= sdram.sdram_addr;
              end
              if (last_word) begin
                state_q <= StDone;
                busy    <= 1'b0;
                done    <= 1'b1;
                pass    <= (err_cnt == 16'd0) && !mismatch;
                led     <= ((err_cnt == 16'd0) && !mismatch) ? 8'h55 : 8'hAA;
              end else begin
                idx_q <= idx_q + 16'd1;
              end
            end else if (timed_out) begin
              state_q   <= StTmo;
              rd_pend_q <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              timeout   <= 1'b1;
              led       <= 8'hF0;
            end else begin
              wait_q <= wait_q + 1'b1;
            end
          end else if (!sdram.sdram_req) begin
            sdram.sdram_req   <= 1'b1;
            sdram.sdram_addr  <= word_addr;
            sdram.sdram_rh_wl <= 1'b1;
            wait_q            <= '0;
          end else if (sdram.sdram_ack) begin
            sdram.sdram_req <= 1'b0;
            rd_pend_q       <= 1'b1;
            // The data beat gets its own response budget.
            wait_q          <= '0;
          end else if (timed_out) begin
            state_q         <= StTmo;
            sdram.sdram_req <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b1;
            timeout         <= 1'b1;
            led             <= 8'hF0;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/sdram_pattern_tester.md
SDRAM_PATTERN_TESTER -- requirements
Module: sdram_pattern_tester

Interface
REQ-001 Parameter ADDR_WIDTH, default 24: width of the sdram_addr bus (row, column and bank as 13+9+2).
REQ-002 Parameter DATA_WIDTH, default 16: width of the SDRAM data word.
REQ-003 Parameter WORD_COUNT, default 256: number of words written and then read per test run, legal range 1..65535.
REQ-004 Parameter START_ADDR, default 0: address of the first word tested.
REQ-005 Parameter ACK_TIMEOUT, default 1023: maximum number of wait cycles allowed for each controller response.
REQ-006 Port clk, in, 1: the single clock; the block uses one clock, and all logic is on its rising edge.
REQ-007 Port reset, in, 1: reset is synchronous and active-high.
REQ-008 Port start, in, 1: a one-cycle pulse that starts a test run.
REQ-009 Port sdram_req, out, 1: request to the sdram_ctrl.
REQ-010 Port sdram_ack, in, 1: the controller accepted the request.
REQ-011 Port sdram_addr, out, ADDR_WIDTH: word address.
REQ-012 Port sdram_rh_wl, out, 1: 1 = read, 0 = write.
REQ-013 Port sdram_data_w, out, DATA_WIDTH: write data.
REQ-014 Port sdram_data_r, in, DATA_WIDTH: read data.
REQ-015 Port sdram_data_r_en, in, 1: read data is valid.
REQ-016 Port busy, out, 1: a test run is in progress.
REQ-017 Port done, out, 1: the last run finished, whether it passed or failed.
REQ-018 Port pass, out, 1: the last run finished with zero errors and no timeout.
REQ-019 Port timeout, out, 1: the last run was aborted on a response timeout.
REQ-020 Port err_cnt, out, 16: number of mismatched words.
REQ-021 Port first_err_addr, out, ADDR_WIDTH: address of the first mismatch.
REQ-022 Port led, out, 8: board status display.

Function
REQ-023 States SHALL be IDLE, WRITE, READ, DONE and TMO.
- IDLE -> WRITE on start.
- WRITE -> READ after WORD_COUNT write acks.
- READ -> DONE after WORD_COUNT read data beats.
- WRITE or READ -> TMO on timeout.
REQ-024 start SHALL be ignored in WRITE and READ.
- start in IDLE, DONE or TMO SHALL clear err_cnt, first_err_addr, done, pass and timeout, and enter WRITE on the next edge.
REQ-025 Handshake:
- sdram_req, sdram_addr, sdram_rh_wl and sdram_data_w SHALL be held stable from the request until sdram_ack is sampled high.
- sdram_req SHALL deassert on the edge after ack, for at least one cycle, before the next request.
REQ-026 Each write SHALL complete on its ack. Each read SHALL complete on the first sdram_data_r_en after its ack, and the next read SHALL NOT be issued before then.
REQ-027 sdram_data_r_en while no read is outstanding SHALL be ignored.
REQ-028 Addressing: word i SHALL use address (START_ADDR + i) mod 2^ADDR_WIDTH, with i running 0..WORD_COUNT-1; the address wraps silently.
REQ-029 On a read beat, the word SHALL be compared with its expected value.
- On a mismatch, err_cnt SHALL increment, saturating at 16'hFFFF.
- first_err_addr SHALL be loaded only on the first mismatch.
REQ-030 Timeout:
- A wait counter SHALL be cleared whenever a request is issued.
- If more than ACK_TIMEOUT cycles pass with no ack (or no data beat in READ), the block SHALL enter TMO, drop sdram_req and set timeout = 1.
REQ-031 Outputs per state:
- busy = 1 in WRITE and READ.
- done = 1 in DONE and TMO.
- pass = 1 only in DONE with err_cnt = 0.
REQ-032 led SHALL be:
- 8'h55 when passed;
- 8'hAA in DONE with errors;
- 8'hF0 in TMO;
- 8'h01 while busy;
- 8'h00 in IDLE.

Reset
REQ-033 Reset SHALL take effect on the first clk edge where reset = 1, including mid-transfer, and SHALL NOT wait for a pending ack.
REQ-034 In reset, the block SHALL be in state IDLE with the following values:
- sdram_req = 0, sdram_rh_wl = 1;
- sdram_addr = 0, sdram_data_w = 0;
- busy = 0, done = 0, pass = 0, timeout = 0;
- err_cnt = 0, first_err_addr = 0, led = 8'h00.

Configuration
REQ-035 Macro SDRAM_TESTER_LFSR_EN selects the data pattern.
- Defined: data SHALL come from a 16-bit Fibonacci LFSR with polynomial x^16+x^14+x^13+x^11+1 and seed 16'hACE1. The LFSR SHALL advance once per word and SHALL be reseeded at the start of both WRITE and READ.
- Undefined: data for word i SHALL be i[15:0] ^ 16'h5A5A.

Verification
REQ-036 The bench SHALL cover these directed scenarios (SDRAM model answers within a few cycles unless stated):
- Pattern build, WORD_COUNT = 4, ideal model, start -> writes 5A5A, 5A5B, 5A58, 5A59 to addr 0..3; reads back; done = 1, pass = 1, led = 8'h55.
- LFSR build, WORD_COUNT = 4 -> first write data 16'hACE1; read phase expects the same sequence; pass = 1.
- Model corrupts the read at addr 2 -> err_cnt = 1, first_err_addr = 2, pass = 0, led = 8'hAA.
- Model never acks the first write -> sdram_req drops ACK_TIMEOUT + 1 cycles after the request; timeout = 1, led = 8'hF0.
- START_ADDR = 24'hFFFFFE, WORD_COUNT = 4 -> addresses FFFFFE, FFFFFF, 000000, 000001.
- reset pulsed while a read is outstanding, then start -> all outputs return to reset values; the new run passes; a stray data_r_en is ignored.
